// File: rtl/window_stream_3x3.sv
// -----------------------------------------------------------------------------
// window_stream_3x3
//
// Streaming 3x3 neighbourhood generator. Takes a raster-order pixel stream of a
// padded frame (1-pixel border included), keeps the two previous rows in line
// buffers and emits one full 3x3 window per interior pixel, together with
// row/frame markers, through a single output register.
//
// Parameters
//   DATA_W    pixel width in bits
//   IMG_W     padded frame width in pixels  (>= 3)
//   IMG_H     padded frame height in pixels (>= 3)
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_pixel/in_sof valid
//   in_ready   block accepts a pixel this cycle (combinational)
//   in_pixel   input pixel, raster order
//   in_sof     marks first pixel of a frame
//   out_valid  out_win and markers valid
//   out_ready  downstream accepts the window
//   out_win    window, slice k (DATA_W*k +: DATA_W) is w(k+1), w1..w9 row-major
//   out_sol    first window of an output row
//   out_eol    last window of an output row
//   out_eof    last window of the frame
//   frame_cnt  frames completed (eof window accepted downstream), wraps
//   sof_err    one-cycle pulse after an in_sof seen away from position (0,0)
// -----------------------------------------------------------------------------
module window_stream_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 258,
  parameter int IMG_H  = 258
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_pixel,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9*DATA_W-1:0]   out_win,
  output logic                  out_sol,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic [15:0]           frame_cnt,
  output logic                  sof_err
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int COL_W = 3 * DATA_W;
  localparam int WIN_W = 9 * DATA_W;

  localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Position of the next pixel to be accepted.
  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;

  // lb0 holds row r-1, lb1 holds row r-2. Not reset: nothing stale is ever
  // emitted because windows need r >= 2.
  logic [DATA_W-1:0] lb0_r [IMG_W];
  logic [DATA_W-1:0] lb1_r [IMG_W];

  // Two most recent window columns (left, middle). Column packing: row 0 (top,
  // oldest line) at the low bits, row 2 (current line) at the high bits.
  logic [COL_W-1:0]  col_a_r;
  logic [COL_W-1:0]  col_b_r;

  logic              accept_s;
  logic              resync_s;
  logic [CW-1:0]     cur_col_s;
  logic [RW-1:0]     cur_row_s;
  logic [CW-1:0]     nxt_col_s;
  logic [RW-1:0]     nxt_row_s;
  logic [DATA_W-1:0] lb0_rd_s;
  logic [DATA_W-1:0] lb1_rd_s;
  logic [COL_W-1:0]  new_col_s;
  logic [WIN_W-1:0]  win_s;
  logic              emit_s;
  logic              sol_s;
  logic              eol_s;
  logic              eof_s;

  // Single output register: room for a new window when empty or draining.
  assign in_ready = !out_valid || out_ready;

  // Effective position of the accepted pixel (in_sof mid-frame forces it to
  // the origin) and the position that follows it.
  always_comb begin
    accept_s  = in_valid && in_ready;
    resync_s  = accept_s && in_sof && ((col_r != COL_ZERO) || (row_r != ROW_ZERO));
    cur_col_s = col_r;
    cur_row_s = row_r;
    nxt_col_s = col_r;
    nxt_row_s = row_r;
    if (resync_s) begin
      cur_col_s = COL_ZERO;
      cur_row_s = ROW_ZERO;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    if (cur_col_s == COL_LAST) begin
      nxt_col_s = COL_ZERO;
      if (cur_row_s == ROW_LAST) begin
        nxt_row_s = ROW_ZERO;
      end else begin
        nxt_row_s = cur_row_s + ROW_ONE;
      end
    end else begin
      nxt_col_s = cur_col_s + COL_ONE;
      nxt_row_s = cur_row_s;
    end
  end

  // Assemble the window: stored left/middle columns plus the incoming column
  // {lb1[c], lb0[c], in_pixel}, and decide whether it is an interior window.
  always_comb begin
    lb0_rd_s  = lb0_r[cur_col_s];
    lb1_rd_s  = lb1_r[cur_col_s];
    new_col_s = {in_pixel, lb0_rd_s, lb1_rd_s};
    win_s     = {WIN_W{1'b0}};
    for (int i = 0; i < 3; i++) begin
      win_s[DATA_W*(3*i+0) +: DATA_W] = col_a_r[DATA_W*i +: DATA_W];
      win_s[DATA_W*(3*i+1) +: DATA_W] = col_b_r[DATA_W*i +: DATA_W];
      win_s[DATA_W*(3*i+2) +: DATA_W] = new_col_s[DATA_W*i +: DATA_W];
    end
    emit_s = (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
    sol_s  = (cur_col_s == COL_TWO);
    eol_s  = (cur_col_s == COL_LAST);
    eof_s  = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
  end

  // Position counters advance only on an accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else if (accept_s) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // Line buffers and column shift registers (no reset, see declarations).
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_r[cur_col_s] <= lb0_rd_s;
      lb0_r[cur_col_s] <= in_pixel;
      col_a_r          <= col_b_r;
      col_b_r          <= new_col_s;
    end
  end

  // Output register: reload on accept, clear on drain without a new window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_win   <= {WIN_W{1'b0}};
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (accept_s) begin
      out_valid <= emit_s;
      if (emit_s) begin
        out_win <= win_s;
        out_sol <= sol_s;
        out_eol <= eol_s;
        out_eof <= eof_s;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Frame counter and resync error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      sof_err   <= 1'b0;
    end else begin
      sof_err <= resync_s;
      if (out_valid && out_ready && out_eof) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_window_stream_3x3.sv
module tb_window_stream_3x3;

  localparam int SW = 6;
  localparam int SH = 5;
  localparam int DW = 258;
  localparam int DH = 258;

  typedef struct packed {
    logic [71:0] win;
    logic        sol;
    logic        eol;
    logic        eof;
  } win_t;

  typedef struct packed {
    logic [7:0] p;
    logic       sof;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small-frame DUT
  logic        s_in_valid = 1'b0, s_in_ready, s_in_sof = 1'b0;
  logic [7:0]  s_in_pixel = 8'd0;
  logic        s_out_valid, s_out_ready = 1'b0;
  logic [71:0] s_out_win;
  logic        s_out_sol, s_out_eol, s_out_eof, s_sof_err;
  logic [15:0] s_frame_cnt;

  // default-size DUT
  logic        d_in_valid = 1'b0, d_in_ready, d_in_sof = 1'b0;
  logic [7:0]  d_in_pixel = 8'd0;
  logic        d_out_valid, d_out_ready = 1'b0;
  logic [71:0] d_out_win;
  logic        d_out_sol, d_out_eol, d_out_eof, d_sof_err;
  logic [15:0] d_frame_cnt;

  window_stream_3x3 #(.DATA_W(8), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pixel(s_in_pixel), .in_sof(s_in_sof),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_win(s_out_win),
    .out_sol(s_out_sol), .out_eol(s_out_eol), .out_eof(s_out_eof),
    .frame_cnt(s_frame_cnt), .sof_err(s_sof_err)
  );

  window_stream_3x3 dut_d (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_pixel(d_in_pixel), .in_sof(d_in_sof),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_win(d_out_win),
    .out_sol(d_out_sol), .out_eol(d_out_eol), .out_eof(d_out_eof),
    .frame_cnt(d_frame_cnt), .sof_err(d_sof_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: image array of the current frame, position index
  logic [7:0] img [SH][SW];
  int   m_k;
  win_t exp_q[$];
  win_t obs_q[$];
  pix_t pq[$];

  // per-test observation counters
  int stall_viol, sof_pulses, n_acc, acc22_cyc, first_ov_cyc, cyc_no;
  logic o_in_hs, o_out_hs;

  function automatic logic [7:0] ramp(input int r, input int c);
    return 8'((r * 7 + c * 3) & 255);
  endfunction

  task automatic model_pix(input logic [7:0] p, input logic sof);
    int r, c;
    win_t w;
    if (sof) m_k = 0;
    r = m_k / SW;
    c = m_k % SW;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w.win[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
      w.sol = (c == 2);
      w.eol = (c == SW - 1);
      w.eof = (c == SW - 1) && (r == SH - 1);
      exp_q.push_back(w);
    end
    m_k = (m_k + 1) % (SW * SH);
  endtask

  task automatic add_pixels(input int off, input int n, input logic sof_first);
    pix_t x;
    for (int k = 0; k < n; k++) begin
      x.p   = 8'((16 * (k / SW) + (k % SW) + off) & 255);
      x.sof = sof_first && (k == 0);
      pq.push_back(x);
      model_pix(x.p, x.sof);
    end
  endtask

  task automatic clear_obs();
    m_k = 0;
    exp_q.delete(); obs_q.delete(); pq.delete();
    stall_viol = 0; sof_pulses = 0; n_acc = 0;
    acc22_cyc = -1; first_ov_cyc = -1; cyc_no = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_in_valid = 1'b0; s_in_sof = 1'b0; s_out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_sof = 1'b0; d_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_obs();
  endtask

  // one cycle on the small DUT: sample just after the falling edge, record
  // handshakes, then advance to the next falling edge
  task automatic tick();
    win_t w;
    #1;
    o_in_hs  = s_in_valid && s_in_ready;
    o_out_hs = s_out_valid && s_out_ready;
    if (s_out_valid && !s_out_ready && s_in_ready) stall_viol++;
    if (s_sof_err) sof_pulses++;
    if (s_out_valid && first_ov_cyc < 0) first_ov_cyc = cyc_no;
    if (o_in_hs) begin
      if (n_acc == 14) acc22_cyc = cyc_no;
      n_acc++;
    end
    if (o_out_hs) begin
      w.win = s_out_win; w.sol = s_out_sol; w.eol = s_out_eol; w.eof = s_out_eof;
      obs_q.push_back(w);
    end
    cyc_no++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input int vpct, input int rpct, input logic drain, output logic timeout);
    int cyc = 0;
    timeout = 1'b0;
    forever begin
      if (pq.size() == 0 && (!drain || !s_out_valid)) break;
      if (cyc >= 2000) begin timeout = 1'b1; break; end
      s_in_valid = (pq.size() > 0) && (int'($urandom_range(99)) < vpct);
      if (pq.size() > 0) begin
        s_in_pixel = pq[0].p;
        s_in_sof   = pq[0].sof;
      end
      s_out_ready = int'($urandom_range(99)) < rpct;
      tick();
      if (o_in_hs) void'(pq.pop_front());
      cyc++;
    end
    s_in_valid  = 1'b0;
    s_in_sof    = 1'b0;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", s_out_valid); else n_pass++;
    n_checks++; if (s_out_win !== 72'd0) $display("FAIL reset_out_win: got %h want 0", s_out_win); else n_pass++;
    n_checks++; if ({s_out_sol, s_out_eol, s_out_eof} !== 3'b000) $display("FAIL reset_markers: got %b want 000", {s_out_sol, s_out_eol, s_out_eof}); else n_pass++;
    n_checks++; if (s_frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", s_frame_cnt); else n_pass++;
    n_checks++; if (s_sof_err !== 1'b0) $display("FAIL reset_sof_err: got %b want 0", s_sof_err); else n_pass++;
    n_checks++; if (s_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", s_in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic to;
    logic [71:0] first_w, last_w;
    first_w = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    last_w  = {8'h45, 8'h44, 8'h43, 8'h35, 8'h34, 8'h33, 8'h25, 8'h24, 8'h23};
    apply_reset();
    add_pixels(0, SW * SH, 1'b1);
    feed(100, 100, 1'b1, to);
    n_checks++; if (to !== 1'b0) $display("FAIL basic_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (obs_q.size() != 12) $display("FAIL basic_count: got %0d want 12", obs_q.size()); else n_pass++;
    n_checks++; if (first_ov_cyc != acc22_cyc + 1) $display("FAIL basic_latency: got cycle %0d want %0d", first_ov_cyc, acc22_cyc + 1); else n_pass++;
    if (obs_q.size() == 12) begin
      n_checks++; if (obs_q[0].win !== first_w || obs_q[0].sol !== 1'b1) $display("FAIL basic_first_win: got %h sol %b want %h sol 1", obs_q[0].win, obs_q[0].sol, first_w); else n_pass++;
      n_checks++; if (obs_q[11].win !== last_w || obs_q[11].eof !== 1'b1) $display("FAIL basic_last_win: got %h eof %b want %h eof 1", obs_q[11].win, obs_q[11].eof, last_w); else n_pass++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL basic_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (s_frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt: got %0d want 1", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_random_handshake();
    logic to;
    apply_reset();
    add_pixels(0, SW * SH, 1'b1);
    feed(60, 50, 1'b1, to);
    n_checks++; if (to !== 1'b0) $display("FAIL rand_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (stall_viol != 0) $display("FAIL rand_in_ready_stall: got %0d cycles want 0", stall_viol); else n_pass++;
    n_checks++; if (s_frame_cnt !== 16'd1) $display("FAIL rand_frame_cnt: got %0d want 1", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic to;
    apply_reset();
    add_pixels(8'h00, SW * SH, 1'b1);
    add_pixels(8'h40, SW * SH, 1'b1);
    add_pixels(8'h80, SW * SH, 1'b1);
    feed(100, 80, 1'b1, to);
    n_checks++; if (to !== 1'b0) $display("FAIL b2b_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (obs_q.size() != 36) $display("FAIL b2b_count: got %0d want 36", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (sof_pulses != 0) $display("FAIL b2b_sof_err: got %0d pulses want 0", sof_pulses); else n_pass++;
    n_checks++; if (s_frame_cnt !== 16'd3) $display("FAIL b2b_frame_cnt: got %0d want 3", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_sof_resync();
    logic to;
    apply_reset();
    add_pixels(8'h00, 3 * SW + 1, 1'b1);   // up to (3,0); next would be (3,1)
    add_pixels(8'h80, SW * SH, 1'b1);
    feed(90, 70, 1'b1, to);
    n_checks++; if (to !== 1'b0) $display("FAIL sof_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (sof_pulses != 1) $display("FAIL sof_err_pulses: got %0d want 1", sof_pulses); else n_pass++;
    n_checks++; if (obs_q.size() != 16) $display("FAIL sof_count: got %0d want 16", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL sof_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (s_frame_cnt !== 16'd1) $display("FAIL sof_frame_cnt: got %0d want 1", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic to;
    apply_reset();
    add_pixels(8'h00, SW * SH, 1'b1);
    feed(100, 100, 1'b1, to);
    n_checks++; if (s_frame_cnt !== 16'd1) $display("FAIL rstmid_pre_frame_cnt: got %0d want 1", s_frame_cnt); else n_pass++;
    add_pixels(8'h10, 3 * SW + 4, 1'b0);   // through (3,3)
    feed(100, 100, 1'b0, to);
    #1;
    n_checks++; if (s_out_valid !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", s_out_valid); else n_pass++;
    n_checks++; if (s_in_ready !== 1'b0) $display("FAIL rstmid_stall_ready: got %b want 0", s_in_ready); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", s_out_valid); else n_pass++;
    n_checks++; if (s_frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt: got %0d want 0", s_frame_cnt); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_obs();
    add_pixels(8'h40, SW * SH, 1'b0);
    feed(100, 100, 1'b1, to);
    n_checks++; if (to !== 1'b0) $display("FAIL rstmid_timeout: got %b want 0", to); else n_pass++;
    n_checks++; if (obs_q.size() != 12) $display("FAIL rstmid_count: got %0d want 12", obs_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (s_frame_cnt !== 16'd1) $display("FAIL rstmid_post_frame_cnt: got %0d want 1", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_default_frame();
    int pr = 0, pc = 0, bad = 0, ir_bad = 0;
    int nwin = 0, nsol = 0, neol = 0, neof = 0;
    logic have_prev = 1'b0;
    logic [71:0] ew;
    apply_reset();
    d_out_ready = 1'b1;
    for (int k = 0; k <= DW * DH; k++) begin
      int r, c;
      r = k / DW;
      c = k % DW;
      if (k < DW * DH) begin
        d_in_valid = 1'b1;
        d_in_pixel = ramp(r, c);
        d_in_sof   = (k == 0);
      end else begin
        d_in_valid = 1'b0;
        d_in_sof   = 1'b0;
      end
      #1;
      if (d_in_ready !== 1'b1) ir_bad++;
      if (have_prev && pr >= 2 && pc >= 2) begin
        if (d_out_valid !== 1'b1) begin
          bad++;
        end else begin
          nwin++;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              ew[8*(3*i+j) +: 8] = ramp(pr - 2 + i, pc - 2 + j);
          if (d_out_win !== ew || d_out_sol !== (pc == 2) || d_out_eol !== (pc == DW - 1) ||
              d_out_eof !== (pc == DW - 1 && pr == DH - 1)) bad++;
          if (d_out_sol) nsol++;
          if (d_out_eol) neol++;
          if (d_out_eof) neof++;
        end
      end else if (d_out_valid !== 1'b0) begin
        bad++;
      end
      pr = r;
      pc = c;
      have_prev = (k < DW * DH);
      @(posedge clk);
      @(negedge clk);
    end
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
    n_checks++; if (nwin != 65536) $display("FAIL dflt_windows: got %0d want 65536", nwin); else n_pass++;
    n_checks++; if (nsol != 256) $display("FAIL dflt_sol: got %0d want 256", nsol); else n_pass++;
    n_checks++; if (neol != 256) $display("FAIL dflt_eol: got %0d want 256", neol); else n_pass++;
    n_checks++; if (neof != 1) $display("FAIL dflt_eof: got %0d want 1", neof); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL dflt_window_content: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (ir_bad != 0) $display("FAIL dflt_in_ready: got %0d low cycles want 0", ir_bad); else n_pass++;
    n_checks++; if (d_frame_cnt !== 16'd1) $display("FAIL dflt_frame_cnt: got %0d want 1", d_frame_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_handshake();
    test_back_to_back();
    test_sof_resync();
    test_reset_mid_frame();
    test_default_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
